// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the register file's single write port between two producers:
//   A - ALU/immediate write-back (latency-critical, normally has priority)
//   B - load/long-latency unit (bounded starvation, forced win after
//       STARVE_LIMIT consecutive denied cycles)
// At most one request is granted per cycle. The granted request is
// registered and presented to the register file in the following cycle.
// Writes to x0 consume the slot but keep Reg_Write_o low.
//
// Parameters:
//   DATA_WIDTH   write-data width
//   ADDR_WIDTH   register index width
//   STARVE_LIMIT consecutive denied cycles of B before B is forced (1..15)
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   a_valid_i/a_rd_i/a_data_i      requester A write request
//   a_ready_o                      A accepted this cycle
//   b_valid_i/b_rd_i/b_data_i      requester B write request
//   b_ready_o                      B accepted this cycle
//   Reg_Write_o                    register-file write enable (registered)
//   Write_Register_o               register-file write index (registered)
//   Write_Data_o                   register-file write data (registered)
//   b_forced_o                     arbiter is in the B_FORCED state
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid_i,
    input  logic [ADDR_WIDTH-1:0] a_rd_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    output logic                  a_ready_o,
    input  logic                  b_valid_i,
    input  logic [ADDR_WIDTH-1:0] b_rd_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  b_ready_o,
    output logic                  Reg_Write_o,
    output logic [ADDR_WIDTH-1:0] Write_Register_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    output logic                  b_forced_o
);

    typedef enum logic {
        A_PRIO   = 1'b0,
        B_FORCED = 1'b1
    } state_t;

    localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

    state_t state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic [4:0] starve_inc;
    logic       a_hs, b_hs;

    logic                  reg_write_p1;
    logic [ADDR_WIDTH-1:0] write_register_p1;
    logic [DATA_WIDTH-1:0] write_data_p1;

    assign starve_inc = {1'b0, starve_q} + 5'd1;
    assign a_hs       = a_valid_i & a_ready_o;
    assign b_hs       = b_valid_i & b_ready_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= A_PRIO;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Grant decode and next-state. Ready depends only on valids and state;
    // reset blocks every handshake while it is held.
    always_comb begin
        a_ready_o = 1'b0;
        b_ready_o = 1'b0;
        state_d   = state_q;
        starve_d  = starve_q;
        if (!reset) begin
            case (state_q)
                A_PRIO: begin
                    a_ready_o = a_valid_i;
                    b_ready_o = b_valid_i & ~a_valid_i;
                end
                B_FORCED: begin
                    b_ready_o = b_valid_i;
                    a_ready_o = a_valid_i & ~b_valid_i;
                end
                default: ;
            endcase
        end

        case (state_q)
            A_PRIO: begin
                if (b_valid_i && !b_ready_o) begin
                    // The denied cycle that would bring the count to the
                    // limit hands the next cycle to B instead.
                    if (starve_inc == LIMIT) begin
                        state_d  = B_FORCED;
                        starve_d = 4'd0;
                    end else begin
                        starve_d = starve_inc[3:0];
                    end
                end else begin
                    starve_d = 4'd0;
                end
            end
            B_FORCED: begin
                starve_d = 4'd0;
                if (b_hs || !b_valid_i) begin
                    state_d = A_PRIO;
                end
            end
            default: begin
                state_d  = A_PRIO;
                starve_d = 4'd0;
            end
        endcase
    end

    // Write-back register stage: the granted request lands here and drives
    // the register file one cycle after the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_p1      <= 1'b0;
            write_register_p1 <= '0;
            write_data_p1     <= '0;
        end else if (a_hs) begin
            reg_write_p1      <= (a_rd_i != '0);
            write_register_p1 <= a_rd_i;
            write_data_p1     <= a_data_i;
        end else if (b_hs) begin
            reg_write_p1      <= (b_rd_i != '0);
            write_register_p1 <= b_rd_i;
            write_data_p1     <= b_data_i;
        end else begin
            reg_write_p1      <= 1'b0;
        end
    end

    // A write already registered when reset arrives is cancelled in the
    // reset cycle itself, so the register file never sees it.
    assign Reg_Write_o      = reg_write_p1 & ~reset;
    assign Write_Register_o = write_register_p1;
    assign Write_Data_o     = write_data_p1;
    assign b_forced_o       = (state_q == B_FORCED);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, with a scoreboard of per-cycle expectations produced by a
// behavioural model and consumed by an independent monitor.
module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_valid_i = 1'b0;
    logic [AW-1:0] a_rd_i = '0;
    logic [DW-1:0] a_data_i = '0;
    logic          a_ready_o;
    logic          b_valid_i = 1'b0;
    logic [AW-1:0] b_rd_i = '0;
    logic [DW-1:0] b_data_i = '0;
    logic          b_ready_o;
    logic          Reg_Write_o;
    logic [AW-1:0] Write_Register_o;
    logic [DW-1:0] Write_Data_o;
    logic          b_forced_o;

    regfile_wb_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .a_valid_i       (a_valid_i),
        .a_rd_i          (a_rd_i),
        .a_data_i        (a_data_i),
        .a_ready_o       (a_ready_o),
        .b_valid_i       (b_valid_i),
        .b_rd_i          (b_rd_i),
        .b_data_i        (b_data_i),
        .b_ready_o       (b_ready_o),
        .Reg_Write_o     (Reg_Write_o),
        .Write_Register_o(Write_Register_o),
        .Write_Data_o    (Write_Data_o),
        .b_forced_o      (b_forced_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          known;
        logic          ar;
        logic          br;
        logic          forced;
        logic          we;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: B's run of consecutive denied cycles, plus the write
    // the register file should see next cycle.
    int            streak = 0;
    logic          m_known = 1'b0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_wr = '0;
    logic [DW-1:0] m_wd = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model decides who wins and what the
    // register file must see, and queues that for the monitor.
    task automatic step(input logic rst,
                        input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] brd, input logic [DW-1:0] bd,
                        output logic a_acc, output logic b_acc);
        exp_t e;
        logic forced;
        @(posedge clk);
        #1;
        reset     = rst;
        a_valid_i = av;
        a_rd_i    = ard;
        a_data_i  = ad;
        b_valid_i = bv;
        b_rd_i    = brd;
        b_data_i  = bd;

        forced = (streak >= LIMIT);
        a_acc  = 1'b0;
        b_acc  = 1'b0;
        if (!rst) begin
            if (forced) begin
                if (bv) b_acc = 1'b1;
                else if (av) a_acc = 1'b1;
            end else begin
                if (av) a_acc = 1'b1;
                else if (bv) b_acc = 1'b1;
            end
        end

        e.rst    = rst;
        e.known  = m_known;
        e.ar     = a_acc;
        e.br     = b_acc;
        e.forced = forced;
        e.we     = m_we & ~rst;
        e.wr     = m_wr;
        e.wd     = m_wd;
        exp_q.push_back(e);

        if (rst) begin
            m_we    = 1'b0;
            m_wr    = '0;
            m_wd    = '0;
            streak  = 0;
            m_known = 1'b1;
        end else begin
            if (a_acc) begin
                m_we = (ard != 0);
                m_wr = ard;
                m_wd = ad;
            end else if (b_acc) begin
                m_we = (brd != 0);
                m_wr = brd;
                m_wd = bd;
            end else begin
                m_we = 1'b0;
            end
            if (bv && !b_acc) streak++;
            else streak = 0;
        end
    endtask

    // Monitor: compares the DUT against the oldest queued expectation once
    // per cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("a_ready", {31'd0, a_ready_o}, {31'd0, e.ar});
                check("b_ready", {31'd0, b_ready_o}, {31'd0, e.br});
                check("reg_write", {31'd0, Reg_Write_o}, {31'd0, e.we});
                if (e.known) begin
                    check("b_forced", {31'd0, b_forced_o}, {31'd0, e.forced});
                    check("write_register", {27'd0, Write_Register_o}, {27'd0, e.wr});
                    check("write_data", Write_Data_o, e.wd);
                end
            end
        end
    end

    initial begin
        logic aa, ba;
        logic          a_pend, b_pend, rst_r;
        logic [AW-1:0] ra, rb;
        logic [DW-1:0] da, db;

        // Reset held two cycles with both requesters valid, then A wins.
        step(1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, aa, ba);
        step(1, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, aa, ba);
        step(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, aa, ba);
        step(0, 0, 5'd0, 32'h0, 1, 5'd2, 32'h22, aa, ba);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, aa, ba);

        // A alone.
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, aa, ba);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, aa, ba);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, aa, ba);

        // Continuous contention: B held until it gets through.
        b_pend = 1'b1;
        for (int i = 0; i < 10 && b_pend; i++) begin
            step(0, 1, 5'($urandom_range(1, 31)), $urandom, 1, 5'd9, 32'h1234, aa, ba);
            if (ba) b_pend = 1'b0;
        end
        step(0, 1, 5'd4, 32'h44, 0, 5'd0, 32'h0, aa, ba);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, aa, ba);

        // x0 write from A while B waits.
        step(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd7, 32'h77, aa, ba);
        step(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h77, aa, ba);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, aa, ba);

        // B drops after two denied cycles, then re-asserts under pressure.
        step(0, 1, 5'd6, 32'h61, 1, 5'd8, 32'h88, aa, ba);
        step(0, 1, 5'd6, 32'h62, 1, 5'd8, 32'h88, aa, ba);
        step(0, 1, 5'd6, 32'h63, 0, 5'd0, 32'h0, aa, ba);
        b_pend = 1'b1;
        for (int i = 0; i < 10 && b_pend; i++) begin
            step(0, 1, 5'd6, 32'h70 + i, 1, 5'd8, 32'h88, aa, ba);
            if (ba) b_pend = 1'b0;
        end
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, aa, ba);

        // Reset arriving the cycle after a grant cancels that write.
        step(0, 1, 5'd3, 32'h3333, 0, 5'd0, 32'h0, aa, ba);
        step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, aa, ba);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, aa, ba);

        // Random traffic honouring the hold-until-accepted protocol.
        a_pend = 1'b0;
        b_pend = 1'b0;
        ra = '0; rb = '0; da = '0; db = '0;
        for (int i = 0; i < 600; i++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1'b1;
                ra = 5'($urandom_range(0, 31));
                da = $urandom;
            end
            if (!b_pend && $urandom_range(0, 3) == 0) begin
                b_pend = 1'b1;
                rb = 5'($urandom_range(0, 31));
                db = $urandom;
            end
            rst_r = ($urandom_range(0, 63) == 0);
            step(rst_r, a_pend, ra, da, b_pend, rb, db, aa, ba);
            if (aa) a_pend = 1'b0;
            if (ba) b_pend = 1'b0;
        end
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, aa, ba);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
